// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the MEM-stage data-memory responder.
package data_mem_responder_pkg;

    // Access width carried with each load/store; 11 behaves as a word access.
    typedef enum logic [1:0] {
        DT_WORD     = 2'b00,
        DT_HALF     = 2'b01,
        DT_BYTE     = 2'b10,
        DT_WORD_ALT = 2'b11
    } dataType_e;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/data_mem_responder_lane_steer.sv
// mem_lane_steer: combinational store-merge into the old array word and
// load-extract with sign/zero extension. Little-endian lanes.
module mem_lane_steer
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]  dataType,
    input  logic [1:0]  byteOffset,
    input  logic        isUnsigned,
    input  logic [31:0] storeData,
    input  logic [31:0] oldWord,
    output logic [31:0] mergedWord,
    output logic [31:0] loadData
);

    logic [15:0] halfVal;
    logic [7:0]  byteVal;

    // Lane selection for both the store merge and the load extract.
    always_comb begin
        mergedWord = storeData;
        loadData   = oldWord;
        halfVal    = '0;
        byteVal    = '0;
        case (dataType_e'(dataType))
            DT_HALF: begin
                mergedWord = oldWord;
                mergedWord[{byteOffset[1], 4'b0000} +: 16] = storeData[15:0];
                halfVal  = oldWord[{byteOffset[1], 4'b0000} +: 16];
                loadData = isUnsigned ? {16'h0000, halfVal} : {{16{halfVal[15]}}, halfVal};
            end
            DT_BYTE: begin
                mergedWord = oldWord;
                mergedWord[{byteOffset, 3'b000} +: 8] = storeData[7:0];
                byteVal  = oldWord[{byteOffset, 3'b000} +: 8];
                loadData = isUnsigned ? {24'h000000, byteVal} : {{24{byteVal[7]}}, byteVal};
            end
            default: begin
                mergedWord = storeData;
                loadData   = oldWord;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle responder for MEM-stage loads/stores.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (adds MisalignErr, suppresses
// misaligned accesses); otherwise low address bits are forced to alignment.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  DataType,
    input  logic        MemUnsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Ready,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic        Stall,
    output logic        MisalignErr
`else
    output logic        Stall
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e          state, stateNext;
    logic [CW-1:0]   cnt, cntNext;
    logic            doAccess;
    logic            isReq;

    logic [AW+1:0]   reqAddr;
    logic [31:0]     reqData;
    logic [1:0]      reqType;
    logic            reqUns;
    logic            reqStore;

    logic [AW+1:0]   opAddr;
    logic [31:0]     opData;
    logic [1:0]      opType;
    logic            opUns;
    logic            opStore;
    logic [1:0]      alignedOff;
    logic [AW-1:0]   wordIdx;
    logic            misalign;
    logic [31:0]     oldWord, mergedWord, loadData;
    logic            unusedAddrBits;

    logic [31:0]     mem [DEPTH];

    assign unusedAddrBits = ^Address[31:AW+2];
    assign isReq = MemRead | MemWrite;

    // With LATENCY==1 the access happens on the acceptance edge, so live inputs
    // are used while IDLE; afterwards the latched request drives the access.
    assign opAddr  = (state == ST_IDLE) ? Address[AW+1:0] : reqAddr;
    assign opData  = (state == ST_IDLE) ? WriteData       : reqData;
    assign opType  = (state == ST_IDLE) ? DataType        : reqType;
    assign opUns   = (state == ST_IDLE) ? MemUnsigned     : reqUns;
    assign opStore = (state == ST_IDLE) ? MemWrite        : reqStore;
    assign wordIdx = opAddr[AW+1:2];
    assign oldWord = mem[wordIdx];

    // Force the lane offset to the natural alignment of the access width.
    always_comb begin
        case (dataType_e'(opType))
            DT_HALF: alignedOff = {opAddr[1], 1'b0};
            DT_BYTE: alignedOff = opAddr[1:0];
            default: alignedOff = 2'b00;
        endcase
    end

`ifdef DMEM_ALIGN_CHECK_EN
    // Flag half accesses off a half boundary and word accesses off a word boundary.
    always_comb begin
        case (dataType_e'(opType))
            DT_HALF: misalign = opAddr[0];
            DT_BYTE: misalign = 1'b0;
            default: misalign = |opAddr[1:0];
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    mem_lane_steer uSteer (
        .dataType   (opType),
        .byteOffset (alignedOff),
        .isUnsigned (opUns),
        .storeData  (opData),
        .oldWord    (oldWord),
        .mergedWord (mergedWord),
        .loadData   (loadData)
    );

    // Next-state, latency count and handshake outputs.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        doAccess  = 1'b0;
        Stall     = 1'b0;
        Ready     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (isReq) begin
                    Stall   = 1'b1;
                    cntNext = CW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        stateNext = ST_DONE;
                        doAccess  = 1'b1;
                    end else begin
                        stateNext = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                Stall   = 1'b1;
                cntNext = cnt - CW'(1);
                // cnt reaches zero on this edge: access now and enter DONE.
                if (cnt == CW'(1)) begin
                    stateNext = ST_DONE;
                    doAccess  = 1'b1;
                end
            end
            ST_DONE: begin
                Ready     = 1'b1;
                stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // State register, counter and registered load data.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ReadData <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (doAccess && !opStore && !misalign)
                ReadData <= loadData;
        end
    end

    // Capture the request on acceptance; both strobes together count as a store.
    always_ff @(posedge Clk) begin
        if (state == ST_IDLE && isReq) begin
            reqAddr  <= Address[AW+1:0];
            reqData  <= WriteData;
            reqType  <= DataType;
            reqUns   <= MemUnsigned;
            reqStore <= MemWrite;
        end
    end

    // Word array write port; reset blocks a pending store.
    always_ff @(posedge Clk) begin
        if (Reset && doAccess && opStore && !misalign)
            mem[wordIdx] <= mergedWord;
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic errFlag;

    // Remember whether the completing access was misaligned.
    always_ff @(posedge Clk) begin
        if (!Reset)
            errFlag <= 1'b0;
        else if (doAccess)
            errFlag <= misalign;
    end

    assign MisalignErr = Ready & errFlag;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (LATENCY=2). Build with
// DMEM_ALIGN_CHECK_EN defined to exercise the misalignment check.
module tb_data_mem_responder;

    localparam int unsigned LAT = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MemRead, MemWrite, MemUnsigned;
    logic [1:0]  DataType;
    logic [31:0] Address, WriteData;
    logic [31:0] ReadData;
    logic        Ready, Stall;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        MisalignErr;
`endif

    typedef struct {
        logic [31:0] rd;
        logic        err;
        string       name;
    } exp_t;

    exp_t        expQ[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] lastRd = '0;

    always #5 Clk = ~Clk;

    data_mem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .DataType    (DataType),
        .MemUnsigned (MemUnsigned),
        .Address     (Address),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .Ready       (Ready),
`ifdef DMEM_ALIGN_CHECK_EN
        .Stall       (Stall),
        .MisalignErr (MisalignErr)
`else
        .Stall       (Stall)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every Ready pulse pops one expected response.
    always @(negedge Clk) begin
        if (Ready === 1'b1) begin
            if (expQ.size() == 0) begin
                check("unexpected Ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                check({e.name, " ReadData"}, ReadData, e.rd);
`ifdef DMEM_ALIGN_CHECK_EN
                check({e.name, " MisalignErr"}, {31'd0, MisalignErr}, {31'd0, e.err});
`endif
            end
        end
    end

    // Issue one request, hold it until Ready, check stall/latency, then release.
    task automatic doReq(input logic rd, input logic wr, input logic [1:0] dt, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] expRd, input logic expErr, input string name);
        int n = 0;
        int stalls = 0;
        exp_t e;
        @(posedge Clk); #1;
        MemRead = rd; MemWrite = wr; DataType = dt; MemUnsigned = uns;
        Address = addr; WriteData = wdata;
        e.rd = expRd; e.err = expErr; e.name = name;
        expQ.push_back(e);
        forever begin
            @(negedge Clk);
            if (Ready === 1'b1) break;
            if (Stall === 1'b1) stalls++;
            n++;
            if (n > 20) break;
        end
        check({name, " latency"}, n, LAT);
        check({name, " stall cycles"}, stalls, LAT);
        check({name, " Stall in DONE"}, {31'd0, Stall}, 32'd0);
        @(posedge Clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge Clk);
        check({name, " single Ready"}, {30'd0, Ready, Stall}, 32'd0);
    endtask

    task automatic store(input logic [1:0] dt, input logic [31:0] addr, input logic [31:0] data,
                         input logic err, input string name);
        doReq(1'b0, 1'b1, dt, 1'b0, addr, data, lastRd, err, name);
    endtask

    task automatic load(input logic [1:0] dt, input logic uns, input logic [31:0] addr,
                        input logic [31:0] exp, input string name);
        doReq(1'b1, 1'b0, dt, uns, addr, '0, exp, 1'b0, name);
        lastRd = exp;
    endtask

    initial begin
        Reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; DataType = 2'b00;
        MemUnsigned = 1'b0; Address = '0; WriteData = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset ReadData", ReadData, 32'h0);
        check("reset Ready/Stall", {30'd0, Ready, Stall}, 32'd0);
        @(posedge Clk); #1 Reset = 1'b1;

        // 1: word store then load
        store(2'b00, 32'h10, 32'hDEADBEEF, 1'b0, "st word 0x10");
        load (2'b00, 1'b0, 32'h10, 32'hDEADBEEF, "ld word 0x10");

        // 2: byte lane 3 with sign/zero extension
        store(2'b00, 32'h10, 32'h00000000, 1'b0, "clr word 0x10");
        store(2'b10, 32'h13, 32'h00000080, 1'b0, "st byte 0x13");
        load (2'b10, 1'b0, 32'h13, 32'hFFFFFF80, "ld sbyte 0x13");
        load (2'b10, 1'b1, 32'h13, 32'h00000080, "ld ubyte 0x13");
        load (2'b00, 1'b0, 32'h10, 32'h80000000, "ld word 0x10 b");

        // 3: upper half merge, lower half signed load
        store(2'b00, 32'h20, 32'hAAAAAAAA, 1'b0, "st word 0x20");
        store(2'b01, 32'h22, 32'h00001234, 1'b0, "st half 0x22");
        load (2'b00, 1'b0, 32'h20, 32'h1234AAAA, "ld word 0x20");
        load (2'b01, 1'b0, 32'h20, 32'hFFFFAAAA, "ld shalf 0x20");
        load (2'b01, 1'b1, 32'h22, 32'h00001234, "ld uhalf 0x22");

        // 4: reset during BUSY discards the pending store
        store(2'b00, 32'h30, 32'h11223344, 1'b0, "st word 0x30");
        @(posedge Clk); #1;
        MemWrite = 1'b1; DataType = 2'b10; Address = 32'h30; WriteData = 32'h55;
        @(posedge Clk); #1 Reset = 1'b0;
        @(posedge Clk); #1;
        MemWrite = 1'b0; Reset = 1'b1;
        @(negedge Clk);
        check("post-reset Ready/Stall", {30'd0, Ready, Stall}, 32'd0);
        check("post-reset ReadData", ReadData, 32'h0);
        lastRd = '0;
        load (2'b00, 1'b0, 32'h30, 32'h11223344, "ld word 0x30");

        // 5: both strobes act as a store
        doReq(1'b1, 1'b1, 2'b00, 1'b0, 32'h40, 32'h0BADF00D, lastRd, 1'b0, "rd+wr 0x40");
        load (2'b11, 1'b0, 32'h40, 32'h0BADF00D, "ld word(11) 0x40");

        // 6: misaligned word store
`ifdef DMEM_ALIGN_CHECK_EN
        store(2'b00, 32'h41, 32'h11111111, 1'b1, "st word 0x41");
        load (2'b00, 1'b0, 32'h40, 32'h0BADF00D, "ld word 0x40 kept");
        doReq(1'b1, 1'b0, 2'b01, 1'b0, 32'h41, '0, lastRd, 1'b1, "ld half 0x41");
`else
        store(2'b00, 32'h41, 32'h11111111, 1'b0, "st word 0x41");
        load (2'b00, 1'b0, 32'h40, 32'h11111111, "ld word 0x40 new");
`endif

        repeat (3) @(posedge Clk);
        check("scoreboard drained", expQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
